// File: rtl/systolic_pkg.sv
// Shared types and helpers for the result drain collector.
//   collect_state_t : collector FSM states
//   result_addr()   : buffer write address for the k-th captured word,
//                     optionally transposing an N x N tile.
package systolic_pkg;

    typedef enum logic [1:0] {IDLE, CAPTURE, STREAM, DONE} collect_state_t;

    // Arrival index k -> buffer slot. Transposed mode stores the k-th word
    // at (k%N)*N + k/N so a linear read-out yields the transposed tile.
    function automatic int unsigned result_addr(input int unsigned k,
                                                input int unsigned n,
                                                input bit          transpose);
        if (transpose)
            return (k % n) * n + k / n;
        return k;
    endfunction

endpackage

// File: rtl/result_buffer.sv
// Simple dual-port result RAM: one write port, one registered read port.
//   clk_i               clock
//   wr_en_i/addr/data   write port, written at the clock edge
//   rd_en_i/rd_addr_i   read request; rd_data_o valid the following cycle
// Contents are never reset.
module result_buffer #(
    parameter int DEPTH      = 64,
    parameter int DATA_WIDTH = 32,
    parameter int AW         = 6
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [AW-1:0]         wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [AW-1:0]         rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i)
            mem[wr_addr_i] <= wr_data_i;
        if (rd_en_i)
            rd_data_q <= mem[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/result_drain_collector.sv
// Captures the non-stallable drain stream of the systolic array into an
// N*N buffer, then replays it to the host over valid/ready.
//   clk_i, rst_i                  clock, synchronous active-high reset
//   arm_i                         open a capture window (IDLE only)
//   drain_data_i/drain_valid_i    array drain stream, no backpressure
//   result_data_o/valid_o/last_o  replay stream, ready_i from host
//   busy_o                        CAPTURE or STREAM
//   complete_o                    one-cycle pulse after the last handshake
//   overflow_o                    sticky: drain beat seen outside CAPTURE
//   count_o                       words captured in the current window
module result_drain_collector
    import systolic_pkg::*;
#(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TRANSPOSE  = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          arm_i,
    input  logic [DATA_WIDTH-1:0]         drain_data_i,
    input  logic                          drain_valid_i,
    output logic [DATA_WIDTH-1:0]         result_data_o,
    output logic                          result_valid_o,
    input  logic                          result_ready_i,
    output logic                          result_last_o,
    output logic                          busy_o,
    output logic                          complete_o,
    output logic                          overflow_o,
    output logic [$clog2(N*N+1)-1:0]      count_o
);

    localparam int DEPTH = N * N;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    collect_state_t        state_q, state_d;
    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  overflow_q, overflow_d;
    // Read in flight (RAM output valid next cycle) and whether it is the last word.
    logic                  rd_pend_q, rd_pend_d;
    logic                  rd_last_pend_q, rd_last_pend_d;
    // Two-entry output queue: out register plus one skid entry.
    logic [1:0]            occ_q, occ_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d;
    logic                  out_last_q, out_last_d, skid_last_q, skid_last_d;

    logic                  wr_en, rd_en, pop, push;
    logic [AW-1:0]         wr_addr;
    logic [DATA_WIDTH-1:0] rd_data;

    result_buffer #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH), .AW(AW)) u_buf (
        .clk_i     (clk_i),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (drain_data_i),
        .rd_en_i   (rd_en),
        .rd_addr_i (AW'(rd_ptr_q)),
        .rd_data_o (rd_data)
    );

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        rd_ptr_d       = rd_ptr_q;
        overflow_d     = overflow_q;
        out_data_d     = out_data_q;
        out_last_d     = out_last_q;
        skid_data_d    = skid_data_q;
        skid_last_d    = skid_last_q;
        wr_en          = 1'b0;
        wr_addr        = AW'(result_addr(32'(count_q), N, TRANSPOSE != 0));
        push           = rd_pend_q;
        pop            = (state_q == STREAM) && (occ_q != 2'd0) && result_ready_i;
        // Issue a read only if the queue can absorb it once it returns:
        // stored + in-flight - leaving this cycle must stay below 2.
        rd_en          = (state_q == STREAM) && (rd_ptr_q < CW'(DEPTH)) &&
                         ((3'(occ_q) + 3'(rd_pend_q)) < (3'd2 + 3'(pop)));
        rd_pend_d      = rd_en;
        rd_last_pend_d = rd_en && (rd_ptr_q == CW'(DEPTH - 1));
        occ_d          = occ_q + 2'(push) - 2'(pop);

        if (rd_en)
            rd_ptr_d = rd_ptr_q + 1'b1;

        // Output queue: pop shifts skid into out, push fills the first free slot.
        if (pop && (occ_q == 2'd2)) begin
            out_data_d = skid_data_q;
            out_last_d = skid_last_q;
            if (push) begin
                skid_data_d = rd_data;
                skid_last_d = rd_last_pend_q;
            end
        end else if (push && ((occ_q == 2'd0) || pop)) begin
            out_data_d = rd_data;
            out_last_d = rd_last_pend_q;
        end else if (push) begin
            skid_data_d = rd_data;
            skid_last_d = rd_last_pend_q;
        end

        case (state_q)
            IDLE: begin
                // arm wins over a coincident drain beat: beat dropped, flag cleared.
                if (arm_i) begin
                    state_d    = CAPTURE;
                    count_d    = '0;
                    rd_ptr_d   = '0;
                    overflow_d = 1'b0;
                end else if (drain_valid_i) begin
                    overflow_d = 1'b1;
                end
            end
            CAPTURE: begin
                if (drain_valid_i) begin
                    wr_en   = 1'b1;
                    count_d = count_q + 1'b1;
                    if (count_q == CW'(DEPTH - 1))
                        state_d = STREAM;
                end
            end
            STREAM: begin
                if (drain_valid_i)
                    overflow_d = 1'b1;
                if (pop && out_last_q)
                    state_d = DONE;
            end
            default: begin
                if (drain_valid_i)
                    overflow_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            count_q        <= '0;
            rd_ptr_q       <= '0;
            overflow_q     <= 1'b0;
            rd_pend_q      <= 1'b0;
            rd_last_pend_q <= 1'b0;
            occ_q          <= 2'd0;
            out_data_q     <= '0;
            out_last_q     <= 1'b0;
            skid_data_q    <= '0;
            skid_last_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            rd_ptr_q       <= rd_ptr_d;
            overflow_q     <= overflow_d;
            rd_pend_q      <= rd_pend_d;
            rd_last_pend_q <= rd_last_pend_d;
            occ_q          <= occ_d;
            out_data_q     <= out_data_d;
            out_last_q     <= out_last_d;
            skid_data_q    <= skid_data_d;
            skid_last_q    <= skid_last_d;
        end
    end

    assign result_valid_o = (state_q == STREAM) && (occ_q != 2'd0);
    assign result_data_o  = out_data_q;
    assign result_last_o  = result_valid_o && out_last_q;
    assign busy_o         = (state_q == CAPTURE) || (state_q == STREAM);
    assign complete_o     = (state_q == DONE);
    assign overflow_o     = overflow_q;
    assign count_o        = count_q;

endmodule

// File: tb/tb_result_drain_collector.sv
module tb_result_drain_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b0, arm = 1'b0, dv = 1'b0, rdy = 1'b1;
    logic [31:0] dd = '0;

    logic [31:0] r0_data, r1_data;
    logic        r0_valid, r0_last, busy0, comp0, ovf0;
    logic        r1_valid, r1_last, busy1, comp1, ovf1;
    logic [4:0]  cnt0, cnt1;

    always #5 clk = ~clk;

    result_drain_collector #(.N(4), .DATA_WIDTH(32), .TRANSPOSE(0)) u_dut (
        .clk_i(clk), .rst_i(rst), .arm_i(arm), .drain_data_i(dd), .drain_valid_i(dv),
        .result_data_o(r0_data), .result_valid_o(r0_valid), .result_ready_i(rdy),
        .result_last_o(r0_last), .busy_o(busy0), .complete_o(comp0),
        .overflow_o(ovf0), .count_o(cnt0));

    result_drain_collector #(.N(4), .DATA_WIDTH(32), .TRANSPOSE(1)) u_dut_t (
        .clk_i(clk), .rst_i(rst), .arm_i(arm), .drain_data_i(dd), .drain_valid_i(dv),
        .result_data_o(r1_data), .result_valid_o(r1_valid), .result_ready_i(rdy),
        .result_last_o(r1_last), .busy_o(busy1), .complete_o(comp1),
        .overflow_o(ovf1), .count_o(cnt1));

    int checks = 0, failures = 0;
    int got_d[$], got_t[$];
    bit got_l[$];
    int complete_cnt, first_valid, hold_err, done_err, cnt_err;
    bit timed_out;
    int exp_t[16] = '{1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15, 4, 8, 12, 16};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Arms, then feeds nwords words base+1.. (every 3rd cycle if gap).
    // Tracks count_o against words sent after every edge.
    task automatic capture(input bit gap, input int base, input int nwords);
        int sent = 0;
        int c = 0;
        cnt_err = 0;
        arm = 1'b1;
        step();
        arm = 1'b0;
        if (cnt0 !== 5'd0 || busy0 !== 1'b1) cnt_err++;
        while (sent < nwords) begin
            if (gap && (c % 3 != 0)) begin
                dv = 1'b0;
            end else begin
                dv = 1'b1;
                dd = 32'(base + sent + 1);
                sent++;
            end
            c++;
            step();
            if (cnt0 !== 5'(sent)) cnt_err++;
        end
        dv = 1'b0;
    endtask

    // Drives ready per mode and records accepted words; no judging here.
    task automatic run_replay(input int mode, input bit inject);
        bit prev_stall = 1'b0, prev_last = 1'b0, done_seen = 1'b0;
        logic [31:0] prev_data = '0;
        int done_cyc = 0;
        got_d.delete(); got_t.delete(); got_l.delete();
        complete_cnt = 0; first_valid = -1; hold_err = 0; done_err = 0; timed_out = 1'b1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            dv = (inject && cyc == 3);
            dd = 32'd777;
            if (r0_valid && first_valid < 0) first_valid = cyc;
            if (prev_stall && (!r0_valid || r0_data !== prev_data || r0_last !== prev_last))
                hold_err++;
            if (comp0) begin
                complete_cnt++;
                if (busy0 !== 1'b0 || r0_valid !== 1'b0) done_err++;
                if (!done_seen) done_cyc = cyc;
                done_seen = 1'b1;
            end
            if (mode == 0) rdy = 1'b1;
            else           rdy = (cyc >= 10 && cyc < 15) ? 1'b0 : (cyc % 2 == 0);
            if (r0_valid && rdy) begin
                got_d.push_back(int'(r0_data));
                got_l.push_back(r0_last);
            end
            if (r1_valid && rdy) got_t.push_back(int'(r1_data));
            prev_stall = r0_valid && !rdy;
            prev_data  = r0_data;
            prev_last  = r0_last;
            if (done_seen && cyc >= done_cyc + 2) begin
                timed_out = 1'b0;
                break;
            end
            step();
        end
        dv  = 1'b0;
        rdy = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        checks++; if (busy0 !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy0); end
        checks++; if (r0_valid !== 1'b0)  begin failures++; $display("FAIL reset_valid got=%0b exp=0", r0_valid); end
        checks++; if (r0_last !== 1'b0)   begin failures++; $display("FAIL reset_last got=%0b exp=0", r0_last); end
        checks++; if (comp0 !== 1'b0)     begin failures++; $display("FAIL reset_complete got=%0b exp=0", comp0); end
        checks++; if (ovf0 !== 1'b0)      begin failures++; $display("FAIL reset_overflow got=%0b exp=0", ovf0); end
        checks++; if (cnt0 !== 5'd0)      begin failures++; $display("FAIL reset_count got=%0d exp=0", cnt0); end
    endtask

    task automatic test_basic();
        capture(1'b0, 0, 16);
        checks++; if (cnt_err != 0) begin failures++; $display("FAIL basic_count_steps got=%0d errs exp=0", cnt_err); end
        run_replay(0, 1'b0);
        checks++; if (timed_out) begin failures++; $display("FAIL basic_timeout got=1 exp=0"); end
        checks++; if (got_d.size() != 16) begin failures++; $display("FAIL basic_len got=%0d exp=16", got_d.size()); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got_d.size() <= i || got_d[i] != i + 1) begin
                failures++; $display("FAIL basic_data[%0d] got=%0d exp=%0d", i, got_d.size() > i ? got_d[i] : -1, i + 1);
            end
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got_t.size() <= i || got_t[i] != exp_t[i]) begin
                failures++; $display("FAIL transpose_data[%0d] got=%0d exp=%0d", i, got_t.size() > i ? got_t[i] : -1, exp_t[i]);
            end
        end
        checks++; if (got_l.size() != 16 || got_l[15] !== 1'b1 || got_l.sum() with (int'(item)) != 1)
            begin failures++; $display("FAIL basic_last got=%0d lasts exp=1 on word 16", got_l.sum() with (int'(item))); end
        checks++; if (complete_cnt != 1) begin failures++; $display("FAIL basic_complete got=%0d exp=1", complete_cnt); end
        checks++; if (done_err != 0) begin failures++; $display("FAIL basic_done_outputs got=%0d exp=0", done_err); end
        checks++; if (first_valid < 2) begin failures++; $display("FAIL basic_first_valid got=%0d exp>=2", first_valid); end
        checks++; if (cnt0 !== 5'd16 || busy0 !== 1'b0) begin failures++; $display("FAIL basic_post got=cnt%0d busy%0b exp=cnt16 busy0", cnt0, busy0); end
    endtask

    task automatic test_gaps();
        capture(1'b1, 0, 16);
        checks++; if (cnt_err != 0) begin failures++; $display("FAIL gaps_count_steps got=%0d errs exp=0", cnt_err); end
        run_replay(0, 1'b0);
        checks++; if (timed_out || got_d.size() != 16) begin failures++; $display("FAIL gaps_len got=%0d exp=16", got_d.size()); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got_d.size() <= i || got_d[i] != i + 1) begin
                failures++; $display("FAIL gaps_data[%0d] got=%0d exp=%0d", i, got_d.size() > i ? got_d[i] : -1, i + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        capture(1'b0, 40, 16);
        run_replay(1, 1'b0);
        checks++; if (timed_out || got_d.size() != 16) begin failures++; $display("FAIL bp_len got=%0d exp=16", got_d.size()); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got_d.size() <= i || got_d[i] != 41 + i) begin
                failures++; $display("FAIL bp_data[%0d] got=%0d exp=%0d", i, got_d.size() > i ? got_d[i] : -1, 41 + i);
            end
        end
        checks++; if (hold_err != 0) begin failures++; $display("FAIL bp_hold got=%0d errs exp=0", hold_err); end
        checks++; if (got_l.size() != 16 || got_l[15] !== 1'b1) begin failures++; $display("FAIL bp_last got=0 exp=1"); end
        checks++; if (complete_cnt != 1) begin failures++; $display("FAIL bp_complete got=%0d exp=1", complete_cnt); end
    endtask

    task automatic test_overflow();
        dv = 1'b1; dd = 32'd55;
        step();
        dv = 1'b0;
        checks++; if (ovf0 !== 1'b1) begin failures++; $display("FAIL ovf_idle got=%0b exp=1", ovf0); end
        checks++; if (cnt0 !== 5'd16) begin failures++; $display("FAIL ovf_idle_count got=%0d exp=16", cnt0); end
        // Drain beat coincident with arm: dropped, flag cleared.
        dv = 1'b1; dd = 32'd99;
        capture(1'b0, 100, 16);
        checks++; if (cnt_err != 0) begin failures++; $display("FAIL ovf_arm_count got=%0d errs exp=0", cnt_err); end
        checks++; if (ovf0 !== 1'b0) begin failures++; $display("FAIL ovf_arm_clear got=%0b exp=0", ovf0); end
        run_replay(0, 1'b1);
        checks++; if (got_d.size() != 16 || got_d[0] != 101 || got_d[15] != 116)
            begin failures++; $display("FAIL ovf_replay got=%0d first=%0d exp=16 first=101", got_d.size(), got_d.size() > 0 ? got_d[0] : -1); end
        checks++; if (ovf0 !== 1'b1) begin failures++; $display("FAIL ovf_stream got=%0b exp=1", ovf0); end
        checks++; if (cnt0 !== 5'd16) begin failures++; $display("FAIL ovf_stream_count got=%0d exp=16", cnt0); end
    endtask

    task automatic test_reset_mid();
        capture(1'b0, 0, 7);
        checks++; if (cnt0 !== 5'd7 || busy0 !== 1'b1) begin failures++; $display("FAIL mid_count got=%0d exp=7", cnt0); end
        checks++; if (ovf0 !== 1'b0) begin failures++; $display("FAIL mid_arm_clears_ovf got=%0b exp=0", ovf0); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (busy0 !== 1'b0 || cnt0 !== 5'd0 || r0_valid !== 1'b0 || comp0 !== 1'b0)
            begin failures++; $display("FAIL mid_reset got=busy%0b cnt%0d exp=busy0 cnt0", busy0, cnt0); end
        capture(1'b0, 200, 16);
        run_replay(0, 1'b0);
        checks++; if (timed_out || got_d.size() != 16) begin failures++; $display("FAIL mid_len got=%0d exp=16", got_d.size()); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got_d.size() <= i || got_d[i] != 201 + i) begin
                failures++; $display("FAIL mid_data[%0d] got=%0d exp=%0d", i, got_d.size() > i ? got_d[i] : -1, 201 + i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
